// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing core.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } axis_phase_e;

  // The phase walks ACTIVE -> FRONT -> SYNC -> BACK as the counter rises,
  // so it is a pure function of the count and its region boundaries.
  function automatic axis_phase_e phase_of(input logic [CNT_W-1:0] cnt,
                                           input logic [CNT_W-1:0] fp_start,
                                           input logic [CNT_W-1:0] sync_start,
                                           input logic [CNT_W-1:0] bp_start);
    if (cnt < fp_start)        return PH_ACTIVE;
    else if (cnt < sync_start) return PH_FRONT;
    else if (cnt < bp_start)   return PH_SYNC;
    else                       return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_timing_core_axis.sv
// vga_axis_counter: one raster axis (pixels in a line or lines in a frame).
// Flags describe the count that will be held after the coming clock edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             sync_nxt_o,
  output logic             active_nxt_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (TOTAL > (1 << CNT_W)) begin : g_total_too_big
    $error("vga_axis_counter: total %0d exceeds %0d", TOTAL, 1 << CNT_W);
  end

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_q, count_d;
  axis_phase_e      phase_d;

  assign wrap_o = adv_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (adv_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  assign phase_d      = phase_of(count_d, FP_START, SYNC_START, BP_START);
  assign sync_nxt_o   = (phase_d == PH_SYNC);
  assign active_nxt_o = (phase_d == PH_ACTIVE);

  // Reset parks on the last count so the first enabled edge lands on 0.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= LAST;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/vga_timing_core.sv
// vga_timing_core: registered VGA raster timing (sync, blanking, position, strobes).
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter; otherwise it reads 0.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  logic h_wrap, h_sync_nxt, h_active_nxt;
  logic v_wrap, v_sync_nxt, v_active_nxt;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .adv_i        (1'b1),
    .count_o      (hpos),
    .wrap_o       (h_wrap),
    .sync_nxt_o   (h_sync_nxt),
    .active_nxt_o (h_active_nxt)
  );

  // Lines advance only on the pixel wrap, so vsync can only move there too.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .adv_i        (h_wrap),
    .count_o      (vpos),
    .wrap_o       (v_wrap),
    .sync_nxt_o   (v_sync_nxt),
    .active_nxt_o (v_active_nxt)
  );

  logic hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q;
  logic hsync_d, vsync_d, display_on_d, line_start_d, frame_start_d;

  // A wrap on an axis means the next count on that axis is 0.
  assign hsync_d       = h_sync_nxt ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_d       = v_sync_nxt ? VSYNC_POL : ~VSYNC_POL;
  assign display_on_d  = h_active_nxt && v_active_nxt;
  assign line_start_d  = h_wrap;
  assign frame_start_d = v_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)             frame_cnt_q <= 8'd0;
    else if (frame_start_d) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: a default 640x480 instance plus a tiny
// positive-polarity instance (16x9 totals) for whole-frame and frame counter runs.
module tb_vga_timing_core;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic       a_hsync, a_vsync, a_display_on, a_line_start, a_frame_start;
  logic [9:0] a_hpos, a_vpos;
  logic [7:0] a_frame_cnt;
  logic       b_hsync, b_vsync, b_display_on, b_line_start, b_frame_start;
  logic [9:0] b_hpos, b_vpos;
  logic [7:0] b_frame_cnt;

  vga_timing_core dut_a (
    .clk(clk), .rst_n(rst_n),
    .hsync(a_hsync), .vsync(a_vsync), .display_on(a_display_on),
    .hpos(a_hpos), .vpos(a_vpos),
    .line_start(a_line_start), .frame_start(a_frame_start),
    .frame_cnt(a_frame_cnt)
  );

  // Small raster: h = 8 active, 2 fp, 3 sync, 3 bp; v = 4 active, 1 fp, 2 sync, 2 bp.
  vga_timing_core #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .hsync(b_hsync), .vsync(b_vsync), .display_on(b_display_on),
    .hpos(b_hpos), .vpos(b_vpos),
    .line_start(b_line_start), .frame_start(b_frame_start),
    .frame_cnt(b_frame_cnt)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] b_exp_fc;

  // driver: advance one clock, leave time for outputs to settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({a_hpos, a_vpos} !== {10'd799, 10'd524}) begin
      n_fail++; $display("FAIL reset_pos_a: got %0d,%0d want 799,524", a_hpos, a_vpos);
    end
    n_checks++;
    if ({a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start} !== 5'b01100) begin
      n_fail++; $display("FAIL reset_flags_a: got de/hs/vs/ls/fs=%b want 01100",
                         {a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start});
    end
    n_checks++;
    if (a_frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_frame_cnt_a: got %0d want 0", a_frame_cnt);
    end
    n_checks++;
    if ({b_hpos, b_vpos} !== {10'd15, 10'd8}) begin
      n_fail++; $display("FAIL reset_pos_b: got %0d,%0d want 15,8", b_hpos, b_vpos);
    end
    n_checks++;
    if ({b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags_b: got de/hs/vs/ls/fs=%b want 00000",
                         {b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start});
    end

    rst_n = 1'b1;
    step();
    n_checks++;
    if ({a_hpos, a_vpos} !== {10'd0, 10'd0}) begin
      n_fail++; $display("FAIL release_pos_a: got %0d,%0d want 0,0", a_hpos, a_vpos);
    end
    n_checks++;
    if ({a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start} !== 5'b11111) begin
      n_fail++; $display("FAIL release_flags_a: got de/hs/vs/ls/fs=%b want 11111",
                         {a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start});
    end
    n_checks++;
    if (a_frame_cnt !== (FC_EN ? 8'd1 : 8'd0)) begin
      n_fail++; $display("FAIL release_frame_cnt_a: got %0d want %0d", a_frame_cnt, FC_EN ? 1 : 0);
    end
  endtask

  task automatic test_line();
    int   fall_at, rise_at, de_fall;
    logic prev_hs, prev_de, exp_hs, exp_de;
    fall_at = -1; rise_at = -1; de_fall = -1;
    prev_hs = a_hsync; prev_de = a_display_on;
    for (int i = 1; i < 800; i++) begin
      step();
      exp_hs = !((i >= 656) && (i < 752));
      exp_de = (i < 640);
      n_checks++;
      if ({a_hpos, a_vpos, a_hsync, a_display_on, a_line_start, a_frame_start} !==
          {10'(i), 10'd0, exp_hs, exp_de, 2'b00}) begin
        n_fail++;
        $display("FAIL line_cycle i=%0d: got h=%0d v=%0d hs=%b de=%b ls=%b fs=%b want h=%0d v=0 hs=%b de=%b ls=0 fs=0",
                 i, a_hpos, a_vpos, a_hsync, a_display_on, a_line_start, a_frame_start, i, exp_hs, exp_de);
      end
      if (prev_hs && !a_hsync && fall_at < 0) fall_at = int'(a_hpos);
      if (!prev_hs && a_hsync && rise_at < 0) rise_at = int'(a_hpos);
      if (prev_de && !a_display_on && de_fall < 0) de_fall = int'(a_hpos);
      prev_hs = a_hsync;
      prev_de = a_display_on;
    end
    n_checks++;
    if (fall_at != 656) begin
      n_fail++; $display("FAIL hsync_fall: got hpos %0d want 656", fall_at);
    end
    n_checks++;
    if (rise_at != 752) begin
      n_fail++; $display("FAIL hsync_rise: got hpos %0d want 752", rise_at);
    end
    n_checks++;
    if (de_fall != 640) begin
      n_fail++; $display("FAIL display_fall: got hpos %0d want 640", de_fall);
    end
    step();
    n_checks++;
    if ({a_hpos, a_vpos, a_line_start, a_frame_start, a_display_on, a_hsync} !==
        {10'd0, 10'd1, 4'b1011}) begin
      n_fail++; $display("FAIL line_wrap: got h=%0d v=%0d ls=%b fs=%b de=%b hs=%b want h=0 v=1 ls=1 fs=0 de=1 hs=1",
                         a_hpos, a_vpos, a_line_start, a_frame_start, a_display_on, a_hsync);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    k = 0;
    while (k < 5000 && !(a_hpos == 10'd300 && a_vpos == 10'd2)) begin
      step();
      k++;
    end
    n_checks++;
    if (!(a_hpos == 10'd300 && a_vpos == 10'd2)) begin
      n_fail++; $display("FAIL mid_reset_reach: got %0d,%0d want 300,2 within 5000 cycles", a_hpos, a_vpos);
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if ({a_hpos, a_vpos, a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start} !==
        {10'd799, 10'd524, 5'b01100}) begin
      n_fail++; $display("FAIL mid_reset_a: got h=%0d v=%0d flags=%b want 799,524 flags=01100",
                         a_hpos, a_vpos, {a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start});
    end
    n_checks++;
    if ({b_hpos, b_vpos, b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start, b_frame_cnt} !==
        {10'd15, 10'd8, 5'b00000, 8'd0}) begin
      n_fail++; $display("FAIL mid_reset_b: got h=%0d v=%0d flags=%b fc=%0d want 15,8 flags=00000 fc=0",
                         b_hpos, b_vpos, {b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start}, b_frame_cnt);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({a_hpos, a_vpos, a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start} !==
        {10'd0, 10'd0, 5'b11111}) begin
      n_fail++; $display("FAIL restart_a: got h=%0d v=%0d flags=%b want 0,0 flags=11111",
                         a_hpos, a_vpos, {a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start});
    end
    n_checks++;
    if ({b_hpos, b_vpos, b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start} !==
        {10'd0, 10'd0, 5'b10011}) begin
      n_fail++; $display("FAIL restart_b: got h=%0d v=%0d flags=%b want 0,0 flags=10011",
                         b_hpos, b_vpos, {b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start});
    end
    b_exp_fc = FC_EN ? 8'd1 : 8'd0;
    n_checks++;
    if (b_frame_cnt !== b_exp_fc) begin
      n_fail++; $display("FAIL restart_frame_cnt_b: got %0d want %0d", b_frame_cnt, b_exp_fc);
    end
  endtask

  task automatic test_frame();
    int   h, v, vs_cycles, fs_gap;
    logic exp_hs, exp_vs, exp_de, exp_ls, exp_fs;
    vs_cycles = 0; fs_gap = -1;
    for (int c = 1; c <= 144; c++) begin
      step();
      h = c % 16;
      v = (c / 16) % 9;
      exp_hs = (h >= 10) && (h < 13);
      exp_vs = (v >= 5) && (v < 7);
      exp_de = (h < 8) && (v < 4);
      exp_ls = (h == 0);
      exp_fs = (h == 0) && (v == 0);
      n_checks++;
      if ({b_hpos, b_vpos, b_hsync, b_vsync, b_display_on, b_line_start, b_frame_start} !==
          {10'(h), 10'(v), exp_hs, exp_vs, exp_de, exp_ls, exp_fs}) begin
        n_fail++;
        $display("FAIL frame_cycle c=%0d: got h=%0d v=%0d hs/vs/de/ls/fs=%b want h=%0d v=%0d hs/vs/de/ls/fs=%b",
                 c, b_hpos, b_vpos, {b_hsync, b_vsync, b_display_on, b_line_start, b_frame_start},
                 h, v, {exp_hs, exp_vs, exp_de, exp_ls, exp_fs});
      end
      if (b_vsync) vs_cycles++;
      if (b_frame_start && fs_gap < 0) fs_gap = c;
      if (exp_fs && FC_EN) b_exp_fc = b_exp_fc + 8'd1;
    end
    n_checks++;
    if (vs_cycles != 32) begin
      n_fail++; $display("FAIL vsync_width: got %0d cycles want 32", vs_cycles);
    end
    n_checks++;
    if (fs_gap != 144) begin
      n_fail++; $display("FAIL frame_period: got %0d cycles want 144", fs_gap);
    end
    n_checks++;
    if (b_frame_cnt !== b_exp_fc) begin
      n_fail++; $display("FAIL frame_cnt_after_frame: got %0d want %0d", b_frame_cnt, b_exp_fc);
    end
  endtask

  task automatic test_frame_cnt();
    int   h, v;
    logic exp_fs;
    for (int c = 1; c <= 256 * 144; c++) begin
      step();
      h = c % 16;
      v = (c / 16) % 9;
      exp_fs = (h == 0) && (v == 0);
      if (exp_fs && FC_EN) b_exp_fc = b_exp_fc + 8'd1;
      n_checks++;
      if ({b_frame_start, b_frame_cnt} !== {exp_fs, b_exp_fc}) begin
        n_fail++; $display("FAIL frame_cnt c=%0d: got fs=%b cnt=%0d want fs=%b cnt=%0d",
                           c, b_frame_start, b_frame_cnt, exp_fs, b_exp_fc);
      end
    end
    n_checks++;
    if (a_frame_cnt !== (FC_EN ? 8'd1 : 8'd0)) begin
      n_fail++; $display("FAIL frame_cnt_a_hold: got %0d want %0d", a_frame_cnt, FC_EN ? 1 : 0);
    end
  endtask

  initial begin
    b_exp_fc = 8'd0;
    test_reset();
    test_line();
    test_mid_reset();
    test_frame();
    test_frame_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_core.md
Name: vga_timing_core

Overview:
Upstream raster timing source for the pixel-generation stages, including the cellular-automaton renderer. It produces registered hsync/vsync, display_on and hpos/vpos, plus line and frame start strobes. Downstream blocks clock row/cell logic from these. All outputs are registered, mutually cycle-aligned and glitch-free.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active low)
VSYNC_POL, 0, active level of vsync (0 = active low)

Ports:
clk  input  1  pixel clock (25.175 MHz nominal)
rst_n  input  1  reset, synchronous, active-low
hsync  output  1  horizontal sync, polarity per HSYNC_POL
vsync  output  1  vertical sync, polarity per VSYNC_POL
display_on  output  1  high while (hpos,vpos) is in the visible area
hpos  output  10  current pixel column, 0..H_TOTAL-1
vpos  output  10  current line, 0..V_TOTAL-1
line_start  output  1  one-cycle strobe, high when hpos==0
frame_start  output  1  one-cycle strobe, high when hpos==0 and vpos==0
frame_cnt  output  8  frame counter (see Optional Feature)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024; elaboration error otherwise.
- Reset (rst_n low at a clk edge):
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1.
  - display_on=0; hsync and vsync at their inactive level.
  - line_start=0, frame_start=0, frame_cnt=0.
  - Reset has priority over everything, including when asserted mid-line or mid-frame.
- First edge with rst_n high: wraps to (0,0) with display_on=1, line_start=1, frame_start=1. Output latency from reset release is 1 cycle.
- Horizontal axis:
  - hpos increments by 1 every cycle.
  - At H_TOTAL-1, hpos wraps to 0 and vpos advances.
- Vertical axis:
  - vpos increments only on the hpos wrap.
  - At V_TOTAL-1 coincident with the hpos wrap, vpos wraps to 0.
- Per-axis phases (state machine per counter): ACTIVE → FRONT → SYNC → BACK → ACTIVE. Phase is derived from the counter value, so no extra state register is needed.
- All outputs are registers computed from the next counter values, so they describe the same pixel as the hpos/vpos presented in that cycle. No combinational output paths.
- hsync is active for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- vsync is active for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491. It changes only together with the hpos wrap.
- display_on = (hpos < H_ACTIVE) and (vpos < V_ACTIVE).
- Strobes are exactly one cycle wide:
  - line_start: once per H_TOTAL cycles.
  - frame_start: once per H_TOTAL*V_TOTAL cycles.

Optional Feature:
Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 in the same cycle that frame_start asserts. It wraps 255→0 and resets to 0.
- Undefined: frame_cnt is constant 0 and no counter flops are synthesised. The port remains present so the interface is fixed.

Decomposition:
- Package vga_timing_pkg holds:
  - Default 640x480@60 timing constants.
  - Derived H_TOTAL/V_TOTAL.
  - The per-axis phase enum (ACTIVE, FRONT, SYNC, BACK).
  - Counter width constant (10).
- Sub-module vga_axis_counter is instantiated twice:
  - Horizontal instance: advance enable tied high.
  - Vertical instance: enabled by the horizontal wrap.
  - Each provides count, wrap flag, sync-active and active-region flags.

Test Plan:
- Hold rst_n low 3 cycles → hpos=799, vpos=524, display_on=0, hsync=1, vsync=1, strobes 0. On release, next cycle hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
- Run one line → hsync falls when hpos=656, rises when hpos=752. display_on falls at hpos=640. After hpos=799, next cycle has hpos=0, vpos=1, line_start=1, frame_start=0.
- Run one full frame → vsync low exactly for vpos 490 and 491, i.e. 1600 cycles. display_on=0 for all vpos ≥480. frame_start recurs after exactly 420000 cycles.
- Assert rst_n at hpos=300, vpos=200 → next cycle shows the reset values above. Sequence restarts cleanly at (0,0) after release.
- Build with HSYNC_POL=1, VSYNC_POL=1 → hsync high only for hpos 656..751, vsync high only for vpos 490..491, both low in reset.
- Build with VGA_TIMING_FRAME_CNT_EN and run 256 frames → frame_cnt steps 0,1,…,255,0, changing in the frame_start cycle. Without the macro, frame_cnt stays 0 throughout.
